usb_rx_packet_buffer: RTL

Packet-level receive buffer directly downstream of `usb_rx`, in the `clk48_i` domain. Drains `usb_rx`'s byte stream, stores each packet speculatively and only commits it once the last byte arrives with `keepPacket` set. Failed packets are rolled back so no partial data ever reaches the protocol engine. Presents committed bytes on a first-word-fall-through valid/ready read port with a per-byte last flag.

---
 rtl/usb_rx_packet_buffer_pkg.sv | 17 +
 rtl/usb_rx_buffer_mem.sv | 27 ++
 rtl/usb_rx_packet_buffer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/usb_rx_packet_buffer_pkg.sv
// Shared definitions for the USB receive packet buffer: default depth, the stored entry
// layout and the PID self-check helper.
package config_pkg;

    localparam int DEPTH_LOG2_DEF = 7;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_buf_entry_t;

    // A valid PID carries its own complement in the upper nibble.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

endpackage

// File: rtl/usb_rx_buffer_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read, so the read port can fall
// through without a pipeline stage.
module usb_rx_buffer_mem
    import config_pkg::*;
#(
    parameter int  DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter type entry_t    = rx_buf_entry_t
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  entry_t                wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output entry_t                rdata_o
);

    entry_t mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// Speculative packet buffer behind usb_rx: bytes are committed only when the packet ends good,
// otherwise rolled back. Define USB_RX_PID_CHECK_EN to also drop packets whose first byte is not a valid PID.
module usb_rx_packet_buffer
    import config_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic       clk48_i,
    input  logic       rst_n_i,
    output logic       rxAcceptNewData_o,
    input  logic       rxDataValid_i,
    input  logic [7:0] rxData_i,
    input  logic       rxIsLastByte_i,
    input  logic       keepPacket_i,
    output logic [7:0] rdData_o,
    output logic       rdLast_o,
    output logic       rdValid_o,
    input  logic       rdReady_i,
    output logic       pktDropped_o,
    output logic [7:0] dropCount_o
);

    localparam int             PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]  DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] commitPtr_q, commitPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic          poison_q, poison_d;
    logic          pktDropped_q, pktDropped_d;
    logic [7:0]    dropCount_q, dropCount_d;

    logic          full, empty, wrEn, isLast, commit, pop, pidBadNow;
    rx_buf_entry_t wrEntry, rdEntry;

    assign full   = (wrPtr_q - rdPtr_q) == DEPTH;
    assign empty  = rdPtr_q == commitPtr_q;
    assign wrEn   = rxDataValid_i && !full && !poison_q;
    assign isLast = rxDataValid_i && rxIsLastByte_i;
    assign pop    = !empty && rdReady_i;

`ifdef USB_RX_PID_CHECK_EN
    logic pidBad_q, pidBad_d;
    logic first_q, first_d;

    // Include the current byte so a single-byte packet is judged on its own PID.
    assign pidBadNow = pidBad_q || (first_q && rxDataValid_i && !pid_ok(rxData_i));

    always_comb begin
        pidBad_d = pidBad_q;
        first_d  = first_q;
        if (rxDataValid_i) begin
            pidBad_d = pidBadNow;
            first_d  = 1'b0;
        end
        if (isLast) begin
            pidBad_d = 1'b0;
            first_d  = 1'b1;
        end
    end

    always_ff @(posedge clk48_i) begin
        if (!rst_n_i) begin
            pidBad_q <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            pidBad_q <= pidBad_d;
            first_q  <= first_d;
        end
    end
`else
    assign pidBadNow = 1'b0;
`endif

    assign commit = isLast && keepPacket_i && !poison_q && !full && !pidBadNow;

    always_ff @(posedge clk48_i) begin
        if (!rst_n_i) begin
            wrPtr_q      <= '0;
            commitPtr_q  <= '0;
            rdPtr_q      <= '0;
            poison_q     <= 1'b0;
            pktDropped_q <= 1'b0;
            dropCount_q  <= 8'd0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            commitPtr_q  <= commitPtr_d;
            rdPtr_q      <= rdPtr_d;
            poison_q     <= poison_d;
            pktDropped_q <= pktDropped_d;
            dropCount_q  <= dropCount_d;
        end
    end

    always_comb begin
        wrPtr_d      = wrPtr_q;
        commitPtr_d  = commitPtr_q;
        rdPtr_d      = rdPtr_q;
        poison_d     = poison_q;
        pktDropped_d = 1'b0;
        dropCount_d  = dropCount_q;
        if (wrEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rxDataValid_i && full) begin
            poison_d = 1'b1;
        end
        if (isLast) begin
            poison_d = 1'b0;
            if (commit) begin
                commitPtr_d = wrPtr_q + 1'b1;
            end else begin
                // Rollback: everything written since the last commit is forgotten.
                wrPtr_d      = commitPtr_q;
                pktDropped_d = 1'b1;
                if (dropCount_q != 8'hFF) begin
                    dropCount_d = dropCount_q + 8'd1;
                end
            end
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    assign wrEntry = '{last: rxIsLastByte_i, data: rxData_i};

    usb_rx_buffer_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .entry_t    (rx_buf_entry_t)
    ) u_mem (
        .clk_i   (clk48_i),
        .we_i    (wrEn),
        .waddr_i (wrPtr_q[DEPTH_LOG2-1:0]),
        .wdata_i (wrEntry),
        .raddr_i (rdPtr_q[DEPTH_LOG2-1:0]),
        .rdata_o (rdEntry)
    );

    // The memory is never cleared, so the read port is gated while nothing is committed.
    always_comb begin
        rxAcceptNewData_o = rst_n_i;
        rdValid_o         = !empty;
        rdData_o          = empty ? 8'h00 : rdEntry.data;
        rdLast_o          = empty ? 1'b0 : rdEntry.last;
        pktDropped_o      = pktDropped_q;
        dropCount_o       = dropCount_q;
    end

endmodule
